// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: mode/state encodings and short simulation timing overrides for run_ctrl.
package run_ctrl_pkg;
  typedef enum logic [1:0] {MODE_STEP = 2'd0, MODE_AUTO, MODE_BURST, MODE_BREAK} mode_e;
  typedef enum logic [2:0] {S_RST = 3'd0, S_IDLE, S_RUN, S_BURST, S_HALT} state_e;
  localparam int unsigned SIM_DEB_CYCLES = 4;
  localparam int unsigned SIM_RST_HOLD = 2;
endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-FF synchroniser plus stability counter; output is a debounced level.
module debounce_sync #(
  parameter int unsigned DEB_CYCLES = 20'hF4240,
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic s0, s1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s0 <= INIT;
      s1 <= INIT;
      dout <= INIT;
      cnt <= '0;
    end else begin
      s0 <= din;
      s1 <= s0;
      if (s1 == dout) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        dout <= s1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: CPU run control (step/auto/burst/breakpoint) emitting a one-cycle clock enable.
// Define RUN_CTRL_CYCLE_CNT_EN to make cycle_count count enables; otherwise it is tied to 0.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 26,
  parameter int unsigned DEB_CYCLES = 20'hF4240,
  parameter int unsigned RST_HOLD = 26'h1AB3F00,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_step,
  input  logic               key_rst,
  input  logic [1:0]         mode_sw,
  input  logic [DIV_W-1:0]   divisor,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]  pc,
  output logic               cpu_ce,
  output logic               cpu_rst,
  output logic               tick,
  output logic               halted,
  output logic [2:0]         fsm_state,
  output logic [31:0]        cycle_count
);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  state_e state, state_n;
  logic [DIV_W-1:0] pcnt, pcnt_n;
  logic [HOLD_W-1:0] hcnt, hcnt_n;
  logic [BURST_W-1:0] bcnt, bcnt_n;
  logic skip, skip_n, pend, pend_n;
  logic step_d, krst_d, bp_d, step_q, krst_q;
  logic [1:0] mode_d, mode_q;
  logic step_ev, rst_ev, mode_chg, bp_hit;
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .INIT(1'b1)) u_step (.clk(clk), .rst(rst), .din(key_step), .dout(step_d));
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .INIT(1'b1)) u_krst (.clk(clk), .rst(rst), .din(key_rst), .dout(krst_d));
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .INIT(1'b0)) u_mode0 (.clk(clk), .rst(rst), .din(mode_sw[0]), .dout(mode_d[0]));
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .INIT(1'b0)) u_mode1 (.clk(clk), .rst(rst), .din(mode_sw[1]), .dout(mode_d[1]));
  debounce_sync #(.DEB_CYCLES(DEB_CYCLES), .INIT(1'b0)) u_bp (.clk(clk), .rst(rst), .din(bp_en), .dout(bp_d));
  assign step_ev = step_q & ~step_d;
  assign rst_ev = krst_q & ~krst_d;
  assign mode_chg = mode_q != mode_d;
  assign bp_hit = mode_d == MODE_BREAK && bp_d && pc == bp_addr && !skip;
  assign tick = state != S_RST && pcnt >= divisor;
  assign cpu_rst = state == S_RST;
  assign halted = state == S_HALT;
  assign fsm_state = state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_RST;
      pcnt <= '0;
      hcnt <= '0;
      bcnt <= '0;
      skip <= 1'b0;
      pend <= 1'b0;
      step_q <= 1'b1;
      krst_q <= 1'b1;
      mode_q <= MODE_STEP;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      hcnt <= hcnt_n;
      bcnt <= bcnt_n;
      skip <= skip_n;
      pend <= pend_n;
      step_q <= step_d;
      krst_q <= krst_d;
      mode_q <= mode_d;
    end
  // reset press beats mode change, which beats the per-state transitions
  always_comb begin
    state_n = state;
    pcnt_n = pcnt >= divisor ? '0 : pcnt + 1'b1;
    hcnt_n = '0;
    bcnt_n = bcnt;
    skip_n = skip;
    pend_n = 1'b0;
    cpu_ce = 1'b0;
    if (rst_ev) begin
      state_n = S_RST;
      pcnt_n = '0;
      bcnt_n = '0;
      skip_n = 1'b0;
    end else if (state == S_RST) begin
      hcnt_n = hcnt + 1'b1;
      pcnt_n = '0;
      bcnt_n = '0;
      skip_n = 1'b0;
      if (hcnt == HOLD_W'(RST_HOLD - 1)) state_n = S_IDLE;
    end else if (mode_chg) begin
      state_n = S_IDLE;
      skip_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_ce = pend;
          pend_n = mode_d == MODE_STEP && step_ev;
          if (mode_d == MODE_AUTO) state_n = S_RUN;
          if (mode_d == MODE_BREAK && step_ev) state_n = S_RUN;
          if (mode_d == MODE_BURST && step_ev) begin
            bcnt_n = burst_len;
            state_n = burst_len != '0 ? S_BURST : S_IDLE;
          end
        end
        S_RUN: begin
          if (bp_hit) state_n = S_HALT;
          else begin
            cpu_ce = tick;
            if (tick) skip_n = 1'b0;
          end
        end
        S_BURST: begin
          cpu_ce = tick;
          if (tick) begin
            bcnt_n = bcnt - 1'b1;
            if (bcnt == BURST_W'(1)) state_n = S_IDLE;
          end
        end
        S_HALT: begin
          if (step_ev) begin
            skip_n = 1'b1;
            state_n = S_RUN;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
`ifdef RUN_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) cycle_count <= '0;
    else cycle_count <= state == S_RST ? '0 : cycle_count + {31'd0, cpu_ce};
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios with a pulse-count scoreboard and immediate assertions.
module tb_run_ctrl;
  import run_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b0, key_step = 1'b1, key_rst = 1'b1, bp_en = 1'b0, pc_clr = 1'b1;
  logic [1:0] mode_sw = 2'd0;
  logic [25:0] divisor = 26'd3;
  logic [7:0] burst_len = 8'd0, bp_addr = 8'd0, pc = 8'd0;
  logic cpu_ce, cpu_rst, tick, halted;
  logic [2:0] fsm_state;
  logic [31:0] cycle_count;
  int checks = 0, errors = 0, cyc = 0;
  int ce_t[$];
  int exp_q[$];
  always #5 clk = ~clk;
  run_ctrl #(.DEB_CYCLES(SIM_DEB_CYCLES), .RST_HOLD(SIM_RST_HOLD)) dut (
    .clk(clk), .rst(rst), .key_step(key_step), .key_rst(key_rst), .mode_sw(mode_sw),
    .divisor(divisor), .burst_len(burst_len), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .tick(tick), .halted(halted),
    .fsm_state(fsm_state), .cycle_count(cycle_count)
  );
  // simple CPU model: pc advances on every enable
  always @(posedge clk) pc <= pc_clr ? 8'd0 : pc + {7'd0, cpu_ce};
  always @(negedge clk) begin
    cyc++;
    if (cpu_ce) ce_t.push_back(cyc);
    if (rst) begin
      checks++;
      assert (!(cpu_ce && cpu_rst)) else begin
        errors++;
        $error("FAIL ce_during_rst got 1 exp 0");
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic sb_pop(input string tag, input int got);
    int e;
    e = exp_q.pop_front();
    check(tag, got, e);
  endtask
  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic window(input int n, output int pulses, output int gmin, output int gmax);
    int s;
    s = ce_t.size();
    gmin = 1 << 30;
    gmax = 0;
    repeat (n) @(negedge clk);
    #1;
    pulses = ce_t.size() - s;
    for (int i = s + 1; i < ce_t.size(); i++) begin
      if (ce_t[i] - ce_t[i-1] < gmin) gmin = ce_t[i] - ce_t[i-1];
      if (ce_t[i] - ce_t[i-1] > gmax) gmax = ce_t[i] - ce_t[i-1];
    end
  endtask
  task automatic press_step();
    key_step = 1'b0;
    tk(10);
    key_step = 1'b1;
  endtask
  initial begin
    int p, gmin, gmax, s, n, exp_cyc;
    tk(5);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(S_RST));
    rst = 1'b1;
    check("hold_0", 32'(cpu_rst), 32'd1);
    tk(1);
    check("hold_1", 32'(cpu_rst), 32'd1);
    tk(1);
    check("hold_done", 32'(cpu_rst), 32'd0);
    check("post_rst_state", 32'(fsm_state), 32'(S_IDLE));
    check("post_rst_ce", 32'(cpu_ce), 32'd0);
    pc_clr = 1'b0;
    exp_q.push_back(1);
    fork
      press_step();
      window(30, p, gmin, gmax);
    join
    sb_pop("step_press", p);
    exp_q.push_back(0);
    fork
      begin key_step = 1'b0; tk(2); key_step = 1'b1; end
      window(20, p, gmin, gmax);
    join
    sb_pop("step_glitch", p);
    mode_sw = 2'd1;
    tk(12);
    check("auto_state", 32'(fsm_state), 32'(S_RUN));
    exp_q.push_back(10);
    window(40, p, gmin, gmax);
    sb_pop("auto_div3", p);
    check("auto_gap_min", gmin, 32'd4);
    check("auto_gap_max", gmax, 32'd4);
    divisor = 26'd0;
    tk(2);
    exp_q.push_back(20);
    window(20, p, gmin, gmax);
    sb_pop("auto_div0", p);
    divisor = 26'd3;
    mode_sw = 2'd2;
    tk(12);
    check("burst_idle", 32'(fsm_state), 32'(S_IDLE));
    burst_len = 8'd5;
    exp_q.push_back(5);
    fork
      press_step();
      window(50, p, gmin, gmax);
    join
    sb_pop("burst5", p);
    check("burst_gap_min", gmin, 32'd4);
    check("burst_gap_max", gmax, 32'd4);
    check("burst_end_state", 32'(fsm_state), 32'(S_IDLE));
    burst_len = 8'd0;
    exp_q.push_back(0);
    fork
      press_step();
      window(30, p, gmin, gmax);
    join
    sb_pop("burst0", p);
    check("burst0_state", 32'(fsm_state), 32'(S_IDLE));
    burst_len = 8'd5;
    s = ce_t.size();
    key_step = 1'b0;
    n = 0;
    while (ce_t.size() < s + 2 && n < 60) begin tk(1); n++; end
    check("abort_two_pulses", 32'(ce_t.size() >= s + 2), 32'd1);
    mode_sw = 2'd0;
    n = 0;
    while (fsm_state != S_IDLE && n < 30) begin tk(1); n++; end
    check("abort_idle", 32'(fsm_state), 32'(S_IDLE));
    check("abort_short", 32'(ce_t.size() - s < 5), 32'd1);
    key_step = 1'b1;
    exp_q.push_back(0);
    window(30, p, gmin, gmax);
    sb_pop("abort_quiet", p);
    mode_sw = 2'd3;
    bp_en = 1'b1;
    bp_addr = 8'h06;
    pc_clr = 1'b1;
    tk(12);
    pc_clr = 1'b0;
    check("break_idle", 32'(fsm_state), 32'(S_IDLE));
    s = ce_t.size();
    key_step = 1'b0;
    n = 0;
    while (!halted && n < 80) begin tk(1); n++; end
    key_step = 1'b1;
    check("break_halted", 32'(halted), 32'd1);
    check("break_pc", 32'(pc), 32'h06);
    exp_q.push_back(6);
    sb_pop("break_enables", ce_t.size() - s);
    tk(10);
    check("halt_holds", 32'(fsm_state), 32'(S_HALT));
    key_step = 1'b0;
    n = 0;
    while (pc != 8'h07 && n < 60) begin tk(1); n++; end
    key_step = 1'b1;
    check("resume_pc", 32'(pc), 32'h07);
    check("resume_not_halted", 32'(halted), 32'd0);
    exp_q.push_back(5);
    window(20, p, gmin, gmax);
    sb_pop("resume_run", p);
    mode_sw = 2'd2;
    bp_en = 1'b0;
    tk(12);
    check("rb_idle", 32'(fsm_state), 32'(S_IDLE));
`ifdef RUN_CTRL_CYCLE_CNT_EN
    exp_cyc = ce_t.size();
`else
    exp_cyc = 0;
`endif
    check("cycle_count", cycle_count, exp_cyc);
    burst_len = 8'd20;
    s = ce_t.size();
    key_step = 1'b0;
    n = 0;
    while (ce_t.size() < s + 2 && n < 60) begin tk(1); n++; end
    check("rb_two_pulses", 32'(ce_t.size() >= s + 2), 32'd1);
    key_rst = 1'b0;
    n = 0;
    while (!cpu_rst && n < 30) begin tk(1); n++; end
    check("rb_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rb_ce_off", 32'(cpu_ce), 32'd0);
    tk(1);
    check("rb_hold", 32'(cpu_rst), 32'd1);
    check("rb_cycle_clear", cycle_count, 32'd0);
    tk(1);
    check("rb_release", 32'(cpu_rst), 32'd0);
    check("rb_state", 32'(fsm_state), 32'(S_IDLE));
    key_step = 1'b1;
    key_rst = 1'b1;
    exp_q.push_back(0);
    window(30, p, gmin, gmax);
    sb_pop("rb_quiet", p);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
